// File: rtl/pepper_window_gen_if.sv
// Pixel-in / window-out bundle for the 3x3 neighbourhood generator.
// The generator itself is the slave; the pixel source / window sink side is the master.
interface pepper_window_gen_if #(
  parameter int unsigned DW = 8
);
  logic          in_valid;
  logic          in_sof;
  logic [DW-1:0] in_pixel;
  logic          out_valid;
  logic          out_eol;
  logic [DW-1:0] P1, P2, P3;
  logic [DW-1:0] P4, P5, P6;
  logic [DW-1:0] P7, P8, P9;

  modport master (
    output in_valid, in_sof, in_pixel,
    input  out_valid, out_eol, P1, P2, P3, P4, P5, P6, P7, P8, P9
  );

  modport slave (
    input  in_valid, in_sof, in_pixel,
    output out_valid, out_eol, P1, P2, P3, P4, P5, P6, P7, P8, P9
  );
endinterface

// File: rtl/pepper_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a shifting 3x3 register array.
// Emits a registered window only for interior pixels; borders are never padded.
module pepper_window_gen #(
  parameter int unsigned IMG_W = 256,
  parameter int unsigned DW    = 8
) (
  input logic                clk,
  input logic                rst_n,
  pepper_window_gen_if.slave bus
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CW-1:0] LastCol = CW'(IMG_W - 1);

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [1:0]    row_q, row_d, cur_row;
  logic          win_ok;
  logic          valid_q, eol_q;
  logic [DW-1:0] win_q [9];
  logic [DW-1:0] lb0 [IMG_W];
  logic [DW-1:0] lb1 [IMG_W];
  logic [DW-1:0] lb0_rd, lb1_rd;

  // A start-of-frame pixel is treated as (0,0) regardless of where the counters were.
  always_comb begin
    cur_col = bus.in_sof ? '0 : col_q;
    cur_row = bus.in_sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (bus.in_valid) begin
      row_d = cur_row;
      if (cur_col == LastCol) begin
        col_d = '0;
        row_d = (cur_row == 2'd2) ? 2'd2 : cur_row + 2'd1;
      end else begin
        col_d = cur_col + CW'(1);
      end
    end
  end

  assign win_ok = bus.in_valid && (cur_row == 2'd2) && (cur_col >= CW'(2));
  assign lb0_rd = lb0[cur_col];
  assign lb1_rd = lb1[cur_col];

  // Read-before-write: the old row r-1 value migrates into the r-2 buffer.
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      lb0[cur_col] <= bus.in_pixel;
      lb1[cur_col] <= lb0_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      eol_q   <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= win_ok;
      if (bus.in_valid) begin
        eol_q    <= win_ok && (cur_col == LastCol);
        win_q[0] <= win_q[1];
        win_q[1] <= win_q[2];
        win_q[2] <= lb1_rd;
        win_q[3] <= win_q[4];
        win_q[4] <= win_q[5];
        win_q[5] <= lb0_rd;
        win_q[6] <= win_q[7];
        win_q[7] <= win_q[8];
        win_q[8] <= bus.in_pixel;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_eol   = eol_q;
  assign bus.P1        = win_q[0];
  assign bus.P2        = win_q[1];
  assign bus.P3        = win_q[2];
  assign bus.P4        = win_q[3];
  assign bus.P5        = win_q[4];
  assign bus.P6        = win_q[5];
  assign bus.P7        = win_q[6];
  assign bus.P8        = win_q[7];
  assign bus.P9        = win_q[8];

endmodule
